// File: rtl/gray_step_ctrl_if.sv
// Command/status bundle for gray_step_ctrl; the master drives commands, the slave is the controller.
// cmd_dir exists only when GRAY_STEP_DOWN_EN is defined.
interface gray_step_ctrl_if #(
  parameter int MOD   = 16,
  parameter int DIV_W = 8
);
  localparam int W = $clog2(MOD);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_cont;
  logic [W-1:0]     cmd_len;
  logic [DIV_W-1:0] cmd_div;
  logic             cmd_clr;
  logic             stop;
  logic             busy;
  logic             done;
  logic [W-1:0]     bin_out;
  logic [W-1:0]     gray_out;
`ifdef GRAY_STEP_DOWN_EN
  logic             cmd_dir;

  modport master (
    output cmd_valid, cmd_cont, cmd_len, cmd_div, cmd_clr, cmd_dir, stop,
    input  cmd_ready, busy, done, bin_out, gray_out
  );
  modport slave (
    input  cmd_valid, cmd_cont, cmd_len, cmd_div, cmd_clr, cmd_dir, stop,
    output cmd_ready, busy, done, bin_out, gray_out
  );
`else
  modport master (
    output cmd_valid, cmd_cont, cmd_len, cmd_div, cmd_clr, stop,
    input  cmd_ready, busy, done, bin_out, gray_out
  );
  modport slave (
    input  cmd_valid, cmd_cont, cmd_len, cmd_div, cmd_clr, stop,
    output cmd_ready, busy, done, bin_out, gray_out
  );
`endif
endinterface

// File: rtl/gray_step_ctrl.sv
// Command-driven sequencer stepping a modulo-MOD counter with registered binary and Gray outputs.
// Optional down-counting via cmd_dir is enabled by defining GRAY_STEP_DOWN_EN.
module gray_step_ctrl #(
  parameter int MOD   = 16,
  parameter int DIV_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  gray_step_ctrl_if.slave bus
);
  localparam int W = $clog2(MOD);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     bin_q, bin_d;
  logic [W-1:0]     gray_q, gray_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [W-1:0]     steps_left_q, steps_left_d;
  logic             cont_q, cont_d;
  logic             dir_q, dir_d;

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1'b1);
  endfunction

  function automatic logic [W-1:0] step_val(input logic [W-1:0] b, input logic down);
    if (down) begin
      return (b == {W{1'b0}}) ? W'(MOD - 1) : b - W'(1);
    end else begin
      return (b == W'(MOD - 1)) ? {W{1'b0}} : b + W'(1);
    end
  endfunction

  // Next-state and datapath computation for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    presc_d      = presc_q;
    div_d        = div_q;
    steps_left_d = steps_left_q;
    cont_d       = cont_q;
    dir_d        = dir_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          cont_d       = bus.cmd_cont;
          div_d        = bus.cmd_div;
          steps_left_d = bus.cmd_len;
          presc_d      = {DIV_W{1'b0}};
`ifdef GRAY_STEP_DOWN_EN
          dir_d        = bus.cmd_dir;
`else
          dir_d        = 1'b0;
`endif
          if (bus.cmd_clr) begin
            bin_d = {W{1'b0}};
          end else begin
            bin_d = bin_q;
          end
          if (!bus.cmd_cont && (bus.cmd_len == {W{1'b0}})) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // stop outranks a coincident prescaler match: abort without stepping
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (presc_q == div_q) begin
          presc_d = {DIV_W{1'b0}};
          bin_d   = step_val(bin_q, dir_q);
          if (!cont_q) begin
            steps_left_d = steps_left_q - W'(1);
            if (steps_left_q == W'(1)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            state_d = S_RUN;
          end
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    gray_d = to_gray(bin_d);
  end

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bin_q        <= {W{1'b0}};
      gray_q       <= {W{1'b0}};
      presc_q      <= {DIV_W{1'b0}};
      div_q        <= {DIV_W{1'b0}};
      steps_left_q <= {W{1'b0}};
      cont_q       <= 1'b0;
      dir_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      gray_q       <= gray_d;
      presc_q      <= presc_d;
      div_q        <= div_d;
      steps_left_q <= steps_left_d;
      cont_q       <= cont_d;
      dir_q        <= dir_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.bin_out   = bin_q;
  assign bus.gray_out  = gray_q;
endmodule

// File: doc/gray_step_ctrl.md
Name: gray_step_ctrl

Overview:
Command-driven sequencer that owns and steps a modulo-MOD binary/Gray counter.
- Accepts run commands over a valid/ready handshake.
- Paces counter steps with a programmable prescaler.
- Runs either a fixed number of steps or continuously until stopped.
- Used wherever a Gray-coded position must advance under control, e.g. pointer stepping or encoder emulation.

Parameters:
MOD, 16, counter modulus; bin_out counts 0..MOD-1 and wraps; MOD >= 2
W, $clog2(MOD), counter, length and Gray width; derived, not overridden
DIV_W, 8, prescaler divisor width

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_cont  in  1  1 = continuous run, 0 = run cmd_len steps
cmd_len  in  W  step count for single-run mode
cmd_div  in  DIV_W  one step every cmd_div+1 cycles
cmd_clr  in  1  clear counter to 0 on accept
stop  in  1  abort current run
busy  out  1  high in RUN
done  out  1  one-cycle pulse when a single run completes
bin_out  out  W  binary counter value
gray_out  out  W  Gray code of bin_out, equal to bin_out ^ (bin_out >> 1)

Behaviour:
- Reset (rst=0, async): state=IDLE, bin_out=0, gray_out=0, busy=0, done=0, prescaler=0, steps_left=0. cmd_ready=1 once rst is released.
- bin_out and gray_out are both registers and always update on the same edge; gray_out is never combinational.
- The counter holds its value between commands unless cmd_clr is set.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid=1, latch cmd_cont, cmd_len and cmd_div; clear the prescaler.
  - If cmd_clr=1, bin_out and gray_out become 0 on that edge.
  - Next state: DONE if cmd_cont=0 and cmd_len=0 (no step taken); otherwise RUN.
- RUN:
  - busy=1, cmd_ready=0. cmd_valid is ignored and no command is captured.
  - The prescaler increments each cycle. On a cycle where prescaler==div, take a step and reset the prescaler to 0.
  - First step lands on edge k+div+1, where k is the accept edge; later steps follow every div+1 cycles. div=0 steps every cycle.
  - Step: bin_out = (bin_out==MOD-1) ? 0 : bin_out+1, with gray_out updated accordingly.
  - Single mode: decrement steps_left on each step. The step with steps_left==1 moves the state to DONE.
  - Continuous mode: runs until stop.
- stop=1 in RUN:
  - Goes to IDLE on the next edge. No step is taken on that edge, even if the prescaler matches.
  - done is not pulsed. The counter keeps its current value.
  - stop is ignored in IDLE and DONE.
- DONE: done=1 for exactly one cycle, busy=0, cmd_ready=0; unconditionally returns to IDLE.
- Reset mid-run: immediately returns to IDLE with all outputs at reset values; no done pulse.
- Non-power-of-2 MOD: the wrap MOD-1 -> 0 may change more than one Gray bit. This is acceptable; all other steps change exactly one bit.

Optional Feature:
GRAY_STEP_DOWN_EN
- Defined: adds input cmd_dir (1 bit), latched on accept.
  - cmd_dir=1 counts down: bin_out = (bin_out==0) ? MOD-1 : bin_out-1.
  - cmd_dir=0 counts up as above.
- Undefined: cmd_dir port does not exist; the counter is up-only.
- All other behaviour is identical in both builds.

Test Plan:
- Async reset: drive rst=0 between clock edges -> bin_out=0, gray_out=0, busy=0 immediately; cmd_ready=1 after release.
- Single run: cmd_len=5, cmd_div=0, cmd_clr=1 ->
  - bin_out steps 1..5 on consecutive edges; final gray_out=4'b0111.
  - done pulses one cycle after the last step; busy low from that cycle.
- Wrap and pacing: start at 14, cmd_len=3, cmd_div=3, MOD=16 ->
  - Steps 15, 0, 1, spaced exactly 4 cycles apart.
  - gray_out sequence 1000, 0000, 0001.
- Continuous plus stop: cmd_cont=1, cmd_div=1, assert stop after 7 cycles ->
  - Counter frozen at 3.
  - No done pulse; IDLE and cmd_ready=1 on the next edge.
  - A cmd_valid pulse during RUN is ignored.
- Zero length: cmd_len=0 single run -> no step, done pulses for exactly one cycle, counter unchanged.
- Reset mid-run: rst=0 during RUN with bin_out=6 -> bin_out=0, busy=0, no done pulse. With GRAY_STEP_DOWN_EN defined, a cmd_dir=1 run of 2 steps from 0 gives bin_out 15 then 14.
